// File: rtl/boot_fetch_pkg.sv
// Shared types and helpers for the boot loader / instruction fetch slice.
package boot_fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic int addr_idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/boot_fetch_unit_if.sv
// Boot byte stream, fetch control and decode-side outputs of boot_fetch_unit.
interface boot_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            load_ready;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            running;
    logic            fault;

    modport master (
        output load_valid, load_byte, load_last, stall, redirect, redirect_addr,
        input  load_ready, instr_valid, instr, instr_pc, running, fault
    );

    modport slave (
        input  load_valid, load_byte, load_last, stall, redirect, redirect_addr,
        output load_ready, instr_valid, instr, instr_pc, running, fault
    );
endinterface

// File: rtl/boot_fetch_unit_fetch_ram.sv
// Single-port instruction RAM: synchronous write, synchronous read with read enable.
module fetch_ram
    import boot_fetch_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = addr_idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // NOTE: the array and read register have no reset so they map onto block RAM; consumers mask stale data.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/boot_fetch_unit.sv
// Instruction fetch stage that first fills its RAM from a boot byte stream, then
// streams one instruction per cycle to decode with stall, redirect and fault handling.
module boot_fetch_unit
    import boot_fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH_WORDS  = 256,
    parameter int              PC_INCR      = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              BIG_ENDIAN   = 1'b1
) (
    input logic              clk,
    input logic              rst,
    boot_fetch_unit_if.slave bus
);
    localparam int              AW        = addr_idx_width(DEPTH_WORDS);
    localparam logic [XLEN:0]   LIMIT     = (XLEN+1)'(DEPTH_WORDS * 4);
    localparam logic [XLEN-1:0] STEP      = XLEN'(PC_INCR);
    localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH_WORDS - 1);

    state_e          r_state, w_state_next;
    logic [1:0]      r_byte_cnt, w_lane;
    logic [AW-1:0]   r_word_cnt, w_ram_addr;
    logic [31:0]     r_asm, w_asm_next, w_ram_rdata;
    logic [XLEN-1:0] r_pc, r_instr_pc;
    logic            r_instr_valid;
    logic            w_accept, w_ram_we, w_ram_re, w_issue, w_redirect_take;
    logic            w_redirect_bad, w_seq_over;

    assign w_redirect_bad = (bus.redirect_addr[1:0] != 2'b00) || ({1'b0, bus.redirect_addr} >= LIMIT);
    assign w_seq_over     = ({1'b0, r_pc} + {1'b0, STEP}) >= LIMIT;

    // Byte packer: the first byte of a word clears the other lanes, which zero-pads short tails.
    always_comb begin
        w_lane     = BIG_ENDIAN ? 2'd3 - r_byte_cnt : r_byte_cnt;
        w_asm_next = (r_byte_cnt == 2'd0) ? 32'd0 : r_asm;
        case (w_lane)
            2'd0:    w_asm_next[7:0]   = bus.load_byte;
            2'd1:    w_asm_next[15:8]  = bus.load_byte;
            2'd2:    w_asm_next[23:16] = bus.load_byte;
            default: w_asm_next[31:24] = bus.load_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_ram_we        = 1'b0;
        w_ram_re        = 1'b0;
        w_issue         = 1'b0;
        w_redirect_take = 1'b0;
        w_ram_addr      = r_word_cnt;
        case (r_state)
            ST_LOAD: begin
                w_accept = bus.load_valid;
                w_ram_we = w_accept && (r_byte_cnt == 2'd3 || bus.load_last);
                if (w_accept && (bus.load_last || (r_byte_cnt == 2'd3 && r_word_cnt == LAST_WORD)))
                    w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_ram_addr = r_pc[AW+1:2];
                if (bus.redirect) begin
                    if (w_redirect_bad) w_state_next = ST_FAULT;
                    else                w_redirect_take = 1'b1;
                end else if (!bus.stall) begin
                    w_issue  = 1'b1;
                    w_ram_re = 1'b1;
                    if (w_seq_over) w_state_next = ST_FAULT;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt    <= 2'd0;
            r_word_cnt    <= '0;
            r_asm         <= 32'd0;
            r_pc          <= RESET_VECTOR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm      <= w_asm_next;
                r_byte_cnt <= bus.load_last ? 2'd0 : r_byte_cnt + 2'd1;
                if (w_ram_we) r_word_cnt <= r_word_cnt + AW'(1);
            end
            // A redirect leaves a one-cycle bubble; its target is issued on the following cycle.
            if (w_state_next == ST_FAULT) begin
                r_instr_valid <= 1'b0;
            end else if (w_redirect_take) begin
                r_instr_valid <= 1'b0;
                r_pc          <= bus.redirect_addr;
            end else if (w_issue) begin
                r_instr_valid <= 1'b1;
                r_instr_pc    <= r_pc;
                r_pc          <= r_pc + STEP;
            end
        end
    end

    fetch_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_asm_next),
        .o_rdata (w_ram_rdata)
    );

    assign bus.load_ready  = (r_state == ST_LOAD);
    assign bus.running     = (r_state == ST_FETCH);
    assign bus.fault       = (r_state == ST_FAULT);
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr       = r_instr_valid ? XLEN'(w_ram_rdata) : '0;
endmodule
